// File: rtl/tank_bullet.sv
// Per-tank projectile engine: launches one bullet on a fire edge, advances it per frame,
// and resolves hits against the screen edge, four walls and the opposing tank.
module tank_bullet #(
  parameter int unsigned SPEED       = 4,
  parameter int unsigned BULLET_SIZE = 8,
  parameter int unsigned TANK_SIZE   = 32,
  parameter int unsigned HWALL_W     = 64,
  parameter int unsigned HWALL_H     = 16,
  parameter int unsigned VWALL_W     = 32,
  parameter int unsigned VWALL_H     = 64,
  parameter int unsigned COOLDOWN    = 15,
  parameter int unsigned SCREEN_W    = 640,
  parameter int unsigned SCREEN_H    = 480
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       fire,
  input  logic [9:0] tankX,
  input  logic [9:0] tankY,
  input  logic [2:0] tank_dir,
  input  logic [9:0] enemyX,
  input  logic [9:0] enemyY,
  input  logic [9:0] wallX1,
  input  logic [9:0] wallY1,
  input  logic [9:0] wallX2,
  input  logic [9:0] wallY2,
  input  logic [9:0] wallX3,
  input  logic [9:0] wallY3,
  input  logic [9:0] wallX4,
  input  logic [9:0] wallY4,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  output logic [9:0] bulletX,
  output logic [9:0] bulletY,
  output logic [1:0] hit,
  output logic       is_bullet,
  output logic       enemy_alive
);

  localparam int unsigned PW = 10;
  localparam int unsigned SW = 12;
  localparam int unsigned CW = $clog2(COOLDOWN + 1);
  localparam int unsigned OFFS = (TANK_SIZE - BULLET_SIZE) / 2;

  localparam logic [1:0] S_IDLE     = 2'b00;
  localparam logic [1:0] S_FLIGHT   = 2'b01;
  localparam logic [1:0] S_HIT_WALL = 2'b10;
  localparam logic [1:0] S_HIT_TANK = 2'b11;

  localparam logic signed [SW-1:0] SPD   = SW'(SPEED);
  localparam logic signed [SW-1:0] BS    = SW'(BULLET_SIZE);
  localparam logic signed [SW-1:0] TS    = SW'(TANK_SIZE);
  localparam logic signed [SW-1:0] HW_W  = SW'(HWALL_W);
  localparam logic signed [SW-1:0] HW_H  = SW'(HWALL_H);
  localparam logic signed [SW-1:0] VW_W  = SW'(VWALL_W);
  localparam logic signed [SW-1:0] VW_H  = SW'(VWALL_H);
  localparam logic signed [SW-1:0] MAX_X = SW'(SCREEN_W - BULLET_SIZE);
  localparam logic signed [SW-1:0] MAX_Y = SW'(SCREEN_H - BULLET_SIZE);
  localparam logic signed [SW-1:0] ZERO  = '0;

  logic [1:0]    state_q, state_d;
  logic [PW-1:0] bx_q, bx_d, by_q, by_d;
  logic          alive_q, alive_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    dir_q, dir_d;
  logic          pend_q, pend_d;
  logic          fs1_q, fs2_q, fprev_q, fire_prev_q;

  logic                 tick, fire_rise, dir_ok;
  logic                 hit_enemy, off_screen, hit_wall;
  logic signed [SW-1:0] step_x, step_y, nx, ny;

  function automatic logic signed [SW-1:0] sx(input logic [PW-1:0] v);
    return signed'(SW'(v));
  endfunction

  // Half-open box overlap
  function automatic logic overlap(
    input logic signed [SW-1:0] ax, ay, aw, ah,
    input logic signed [SW-1:0] bx, by, bw, bh
  );
    return (ax < bx + bw) && (bx < ax + aw) && (ay < by + bh) && (by < ay + ah);
  endfunction

  assign tick      = fs2_q & ~fprev_q;
  assign fire_rise = fire & ~fire_prev_q;
  assign dir_ok    = (tank_dir == 3'b001) || (tank_dir == 3'b010) ||
                     (tank_dir == 3'b011) || (tank_dir == 3'b100);

  always_comb begin
    step_x = '0;
    step_y = '0;
    case (dir_q)
      3'b001:  step_y = -SPD;
      3'b010:  step_x = SPD;
      3'b011:  step_x = -SPD;
      3'b100:  step_y = SPD;
      default: ;
    endcase
  end

  assign nx = sx(bx_q) + step_x;
  assign ny = sx(by_q) + step_y;

  assign hit_enemy  = alive_q && overlap(nx, ny, BS, BS, sx(enemyX), sx(enemyY), TS, TS);
  assign off_screen = (nx < ZERO) || (ny < ZERO) || (nx > MAX_X) || (ny > MAX_Y);
  assign hit_wall   = overlap(nx, ny, BS, BS, sx(wallX1), sx(wallY1), HW_W, HW_H) ||
                      overlap(nx, ny, BS, BS, sx(wallX2), sx(wallY2), VW_W, VW_H) ||
                      overlap(nx, ny, BS, BS, sx(wallX3), sx(wallY3), HW_W, HW_H) ||
                      overlap(nx, ny, BS, BS, sx(wallX4), sx(wallY4), VW_W, VW_H);

  // Next-state: everything advances only on a frame tick
  always_comb begin
    state_d = state_q;
    bx_d    = bx_q;
    by_d    = by_q;
    alive_d = alive_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    // a pending fire survives only until the next tick, whatever the state
    pend_d  = fire_rise | (pend_q & ~tick);
    if (tick) begin
      case (state_q)
        S_IDLE: begin
          if (pend_q && alive_q && dir_ok) begin
            dir_d   = tank_dir;
            bx_d    = tankX + PW'(OFFS);
            by_d    = tankY + PW'(OFFS);
            state_d = S_FLIGHT;
          end
        end
        S_FLIGHT: begin
          if (hit_enemy) begin
            alive_d = 1'b0;
            bx_d    = PW'(nx);
            by_d    = PW'(ny);
            state_d = S_HIT_TANK;
          end else if (off_screen || hit_wall) begin
            cnt_d   = CW'(COOLDOWN);
            state_d = S_HIT_WALL;
          end else begin
            bx_d = PW'(nx);
            by_d = PW'(ny);
          end
        end
        S_HIT_WALL: begin
          if (cnt_q <= CW'(1)) begin
            cnt_d   = '0;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= S_IDLE;
      bx_q        <= '0;
      by_q        <= '0;
      alive_q     <= 1'b1;
      cnt_q       <= '0;
      dir_q       <= 3'b000;
      pend_q      <= 1'b0;
      fs1_q       <= 1'b0;
      fs2_q       <= 1'b0;
      fprev_q     <= 1'b0;
      fire_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bx_q        <= bx_d;
      by_q        <= by_d;
      alive_q     <= alive_d;
      cnt_q       <= cnt_d;
      dir_q       <= dir_d;
      pend_q      <= pend_d;
      fs1_q       <= frame_clk;
      fs2_q       <= fs1_q;
      fprev_q     <= fs2_q;
      fire_prev_q <= fire;
    end
  end

  assign hit         = state_q;
  assign bulletX     = bx_q;
  assign bulletY     = by_q;
  assign enemy_alive = alive_q;

  assign is_bullet = (state_q == S_FLIGHT) &&
                     (DrawX >= bx_q) && ({1'b0, DrawX} < {1'b0, bx_q} + 11'(BULLET_SIZE)) &&
                     (DrawY >= by_q) && ({1'b0, DrawY} < {1'b0, by_q} + 11'(BULLET_SIZE));

endmodule

// File: tb/tb_tank_bullet.sv
// Directed bench for tank_bullet: vector tables for launch direction and pixel hit-test,
// plus hand-written sequences for edge, wall, tank, cooldown, held-fire and async reset.
module tb_tank_bullet;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       frame_clk = 1'b0;
  logic       fire = 1'b0;
  logic [9:0] tankX, tankY, enemyX, enemyY;
  logic [2:0] tank_dir;
  logic [9:0] wallX1, wallY1, wallX2, wallY2, wallX3, wallY3, wallX4, wallY4;
  logic [9:0] DrawX, DrawY;
  logic [9:0] bulletX, bulletY;
  logic [1:0] hit;
  logic       is_bullet, enemy_alive;

  int total = 0;
  int bad   = 0;

  tank_bullet dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .fire(fire),
    .tankX(tankX), .tankY(tankY), .tank_dir(tank_dir),
    .enemyX(enemyX), .enemyY(enemyY),
    .wallX1(wallX1), .wallY1(wallY1), .wallX2(wallX2), .wallY2(wallY2),
    .wallX3(wallX3), .wallY3(wallY3), .wallX4(wallX4), .wallY4(wallY4),
    .DrawX(DrawX), .DrawY(DrawY),
    .bulletX(bulletX), .bulletY(bulletY), .hit(hit),
    .is_bullet(is_bullet), .enemy_alive(enemy_alive)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [2:0] dir;
    int         ex;
    int         ey;
    int         eh;
  } dir_vec_t;

  typedef struct {
    int   dx;
    int   dy;
    logic eb;
  } pix_vec_t;

  dir_vec_t dvec[6];
  pix_vec_t pvec[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic set_scene();
    tankX = 10'd100; tankY = 10'd100; tank_dir = 3'b010;
    enemyX = 10'd400; enemyY = 10'd400;
    wallX1 = 10'd500; wallY1 = 10'd20;
    wallX2 = 10'd20;  wallY2 = 10'd300;
    wallX3 = 10'd500; wallY3 = 10'd440;
    wallX4 = 10'd580; wallY4 = 10'd300;
    DrawX = 10'd0; DrawY = 10'd0;
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset = 1'b1; fire = 1'b0; frame_clk = 1'b0;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
  endtask

  // One frame strobe; returns on a negedge after the state has updated
  task automatic tick();
    frame_clk = 1'b1;
    repeat (4) @(negedge Clk);
    frame_clk = 1'b0;
    repeat (2) @(negedge Clk);
  endtask

  task automatic pulse_fire();
    fire = 1'b1;
    @(negedge Clk);
    fire = 1'b0;
    @(negedge Clk);
  endtask

  initial begin
    dvec[0] = '{3'b001, 212, 208, 1};
    dvec[1] = '{3'b010, 216, 212, 1};
    dvec[2] = '{3'b011, 208, 212, 1};
    dvec[3] = '{3'b100, 212, 216, 1};
    dvec[4] = '{3'b000, 0,   0,   0};
    dvec[5] = '{3'b111, 0,   0,   0};

    pvec[0] = '{116, 119, 1'b1};
    pvec[1] = '{124, 119, 1'b0};
    pvec[2] = '{115, 112, 1'b0};
    pvec[3] = '{123, 112, 1'b1};
    pvec[4] = '{116, 120, 1'b0};
    pvec[5] = '{116, 111, 1'b0};
    pvec[6] = '{123, 119, 1'b1};

    set_scene();
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    repeat (3) @(negedge Clk);

    // Reset state
    chk("rst_hit", 32'(hit), 0);
    chk("rst_bx", 32'(bulletX), 0);
    chk("rst_by", 32'(bulletY), 0);
    chk("rst_alive", 32'(enemy_alive), 1);
    for (int i = 0; i < 3; i++) begin
      DrawX = 10'(i * 3); DrawY = 10'(i * 2);
      #1 chk("rst_isb", 32'(is_bullet), 0);
    end

    // Launch per direction: two ticks after fire from tank (200,200)
    foreach (dvec[i]) begin
      do_reset();
      set_scene();
      tankX = 10'd200; tankY = 10'd200; tank_dir = dvec[i].dir;
      pulse_fire();
      tick();
      tick();
      chk($sformatf("dir%0d_hit", i), 32'(hit), 32'(dvec[i].eh));
      chk($sformatf("dir%0d_bx", i), 32'(bulletX), 32'(dvec[i].ex));
      chk($sformatf("dir%0d_by", i), 32'(bulletY), 32'(dvec[i].ey));
    end

    // Right from (100,100): (112,112) then (116,112), pixel tests
    do_reset();
    set_scene();
    pulse_fire();
    tick();
    chk("r_t1_hit", 32'(hit), 1);
    chk("r_t1_bx", 32'(bulletX), 112);
    chk("r_t1_by", 32'(bulletY), 112);
    tick();
    chk("r_t2_bx", 32'(bulletX), 116);
    foreach (pvec[i]) begin
      DrawX = 10'(pvec[i].dx); DrawY = 10'(pvec[i].dy);
      #1 chk($sformatf("pix%0d", i), 32'(is_bullet), 32'(pvec[i].eb));
    end

    // Left edge from (0,200) and cooldown
    do_reset();
    set_scene();
    tankX = 10'd0; tankY = 10'd200; tank_dir = 3'b011;
    pulse_fire();
    for (int t = 0; t < 4; t++) begin
      tick();
      chk($sformatf("edge_t%0d_bx", t + 1), 32'(bulletX), 32'(12 - 4 * t));
    end
    tick();
    chk("edge_hit", 32'(hit), 2);
    chk("edge_bx", 32'(bulletX), 0);
    pulse_fire();
    repeat (14) tick();
    chk("cool14_hit", 32'(hit), 2);
    tick();
    chk("cool15_hit", 32'(hit), 0);

    // Enemy at (140,100): hit on the tick whose next X is 136
    do_reset();
    set_scene();
    enemyX = 10'd140; enemyY = 10'd100;
    pulse_fire();
    repeat (6) tick();
    chk("tank_pre_hit", 32'(hit), 1);
    chk("tank_pre_bx", 32'(bulletX), 132);
    tick();
    chk("tank_hit", 32'(hit), 3);
    chk("tank_alive", 32'(enemy_alive), 0);
    chk("tank_bx", 32'(bulletX), 136);
    pulse_fire();
    repeat (2) tick();
    chk("tank_nolaunch", 32'(hit), 3);
    chk("tank_alive2", 32'(enemy_alive), 0);

    // Wall 1 at (130,104): next X 124 overlaps, position holds at 120
    do_reset();
    set_scene();
    wallX1 = 10'd130; wallY1 = 10'd104;
    pulse_fire();
    repeat (3) tick();
    chk("wall_pre_hit", 32'(hit), 1);
    tick();
    chk("wall_hit", 32'(hit), 2);
    chk("wall_bx", 32'(bulletX), 120);
    chk("wall_alive", 32'(enemy_alive), 1);

    // Enemy at (128,100) and the same wall overlap on one tick: tank wins
    do_reset();
    set_scene();
    wallX1 = 10'd130; wallY1 = 10'd104;
    enemyX = 10'd128; enemyY = 10'd100;
    pulse_fire();
    repeat (3) tick();
    chk("both_pre_hit", 32'(hit), 1);
    tick();
    chk("both_hit", 32'(hit), 3);
    chk("both_bx", 32'(bulletX), 124);
    chk("both_alive", 32'(enemy_alive), 0);

    // Fire held through flight, impact and cooldown: exactly one launch
    do_reset();
    set_scene();
    tankX = 10'd0; tankY = 10'd200; tank_dir = 3'b011;
    fire = 1'b1;
    tick();
    chk("held_t1_hit", 32'(hit), 1);
    repeat (4) tick();
    chk("held_t5_hit", 32'(hit), 2);
    repeat (15) tick();
    chk("held_t20_hit", 32'(hit), 0);
    repeat (2) tick();
    chk("held_t22_hit", 32'(hit), 0);
    fire = 1'b0;

    // Async reset mid-flight with a fire pending
    do_reset();
    set_scene();
    pulse_fire();
    repeat (2) tick();
    chk("ar_pre_hit", 32'(hit), 1);
    pulse_fire();
    @(negedge Clk);
    #2 Reset = 1'b1;
    #1;
    chk("ar_hit", 32'(hit), 0);
    chk("ar_bx", 32'(bulletX), 0);
    @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    tick();
    chk("ar_nolaunch", 32'(hit), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
